wb_commit_unit: RTL and testbench

- Writeback/commit block that drives the single register-file write port (write_enable, waddr, wdata).
- Arbitrates between two result producers, the ALU and the load/store unit (LSU), using valid/ready handshakes.
- Registers the winning result for one cycle.
- Keeps a pending-write scoreboard (busy bitmap) that issue logic uses to stall on RAW hazards.

---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_scoreboard.sv | 47 ++++
 rtl/wb_commit_unit.sv | 113 +++++++++++
 tb/tb_wb_commit_unit.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared constants and types for the writeback/commit unit.
package wb_pkg;

  localparam int XLEN   = 64;
  localparam int NREG   = 32;
  localparam int REG_AW = 5;

  // Result producer identity, also the encoding of the round-robin pointer.
  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LSU = 1'b1
  } wb_src_e;

  // One result heading for the register file.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_result_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// An issue sets a bit, an accepted result clears it, and a set in the same
// cycle as a clear wins because it belongs to the newer instruction.
// Register 0 is hardwired and never reports busy.
module wb_scoreboard
  import wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_rd,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_rd,
  output logic [NREG-1:0]   busy
);

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign busy[gi] = 1'b0;
      end else begin : g_bit
        localparam logic [REG_AW-1:0] IDX = REG_AW'(gi);
        logic bit_reg;
        logic set_hit;
        logic clr_hit;

        assign set_hit = set_en && (set_rd == IDX);
        assign clr_hit = clr_en && (clr_rd == IDX);

        // Per-register busy flag; set has priority over clear.
        always_ff @(posedge clk) begin
          if (!rst) begin
            bit_reg <= 1'b0;
          end else if (set_hit) begin
            bit_reg <= 1'b1;
          end else if (clr_hit) begin
            bit_reg <= 1'b0;
          end
        end

        assign busy[gi] = bit_reg;
      end
    end
  endgenerate

endmodule

// File: rtl/wb_commit_unit.sv
// Writeback/commit unit: arbitrates ALU and LSU results onto the single
// register-file write port through a one-cycle output register, and keeps
// the RAW-hazard busy scoreboard up to date.
// Optional macro WB_ROUND_ROBIN_EN: alternate grants between ALU and LSU on
// contested cycles instead of giving the LSU fixed priority.
module wb_commit_unit
  import wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [REG_AW-1:0] lsu_rd,
  input  logic [XLEN-1:0]   lsu_data,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rd,
  output logic [NREG-1:0]   busy,
  output logic              write_enable,
  output logic [REG_AW-1:0] waddr,
  output logic [XLEN-1:0]   wdata
);

  logic              alu_fire;
  logic              lsu_fire;
  logic              any_fire;
  wb_result_t        sel_result;
  logic              we_reg;
  logic [REG_AW-1:0] waddr_reg;
  logic [XLEN-1:0]   wdata_reg;

`ifdef WB_ROUND_ROBIN_EN
  wb_src_e prio_reg;
  wb_src_e prio_next;
  logic    contested;

  // Ready generation: the pointer names the source that wins the next contest.
  always_comb begin
    contested = alu_valid && lsu_valid;
    alu_ready = rst && alu_valid && (!lsu_valid || (prio_reg == WB_SRC_ALU));
    lsu_ready = rst && lsu_valid && (!alu_valid || (prio_reg == WB_SRC_LSU));
    prio_next = prio_reg;
    if (contested) begin
      prio_next = (prio_reg == WB_SRC_ALU) ? WB_SRC_LSU : WB_SRC_ALU;
    end
  end

  // Pointer flop; only contested cycles move it, so the first contest goes to the ALU.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prio_reg <= WB_SRC_ALU;
    end else begin
      prio_reg <= prio_next;
    end
  end
`else
  // Fixed priority: the LSU is always ready, the ALU yields whenever a load is valid.
  assign lsu_ready = rst;
  assign alu_ready = rst && !lsu_valid;
`endif

  assign alu_fire = alu_valid && alu_ready;
  assign lsu_fire = lsu_valid && lsu_ready;
  assign any_fire = alu_fire || lsu_fire;

  // Winning result; at most one source fires per cycle.
  always_comb begin
    sel_result.rd   = alu_rd;
    sel_result.data = alu_data;
    if (lsu_fire) begin
      sel_result.rd   = lsu_rd;
      sel_result.data = lsu_data;
    end
  end

  // Output register. Address and data are zeroed on idle and x0 cycles because
  // the register file forwards wdata on an address match even without a strobe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      we_reg    <= 1'b0;
      waddr_reg <= '0;
      wdata_reg <= '0;
    end else if (any_fire && (sel_result.rd != '0)) begin
      we_reg    <= 1'b1;
      waddr_reg <= sel_result.rd;
      wdata_reg <= sel_result.data;
    end else begin
      we_reg    <= 1'b0;
      waddr_reg <= '0;
      wdata_reg <= '0;
    end
  end

  // Gating with rst drops a registered result the moment reset asserts, so
  // nothing reaches the register file at the edge where reset is sampled.
  assign write_enable = we_reg && rst;
  assign waddr        = rst ? waddr_reg : '0;
  assign wdata        = rst ? wdata_reg : '0;

  wb_scoreboard u_scoreboard (
    .clk    (clk),
    .rst    (rst),
    .set_en (issue_valid),
    .set_rd (issue_rd),
    .clr_en (any_fire),
    .clr_rd (sel_result.rd),
    .busy   (busy)
  );

endmodule

// File: tb/tb_wb_commit_unit.sv
// Self-checking bench for wb_commit_unit: reset, a vector table, directed
// contention/scoreboard/x0/reset sequences and a randomized run against a
// behavioural model. Works with or without WB_ROUND_ROBIN_EN.
module tb_wb_commit_unit;
  import wb_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              alu_valid;
  logic              alu_ready;
  logic [REG_AW-1:0] alu_rd;
  logic [XLEN-1:0]   alu_data;
  logic              lsu_valid;
  logic              lsu_ready;
  logic [REG_AW-1:0] lsu_rd;
  logic [XLEN-1:0]   lsu_data;
  logic              issue_valid;
  logic [REG_AW-1:0] issue_rd;
  logic [NREG-1:0]   busy;
  logic              write_enable;
  logic [REG_AW-1:0] waddr;
  logic [XLEN-1:0]   wdata;

  always #5 clk = ~clk;

  wb_commit_unit dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .lsu_valid    (lsu_valid),
    .lsu_ready    (lsu_ready),
    .lsu_rd       (lsu_rd),
    .lsu_data     (lsu_data),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .busy         (busy),
    .write_enable (write_enable),
    .waddr        (waddr),
    .wdata        (wdata)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    alu_valid   = 1'b0;
    alu_rd      = '0;
    alu_data    = '0;
    lsu_valid   = 1'b0;
    lsu_rd      = '0;
    lsu_data    = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
  endtask

  // Leaves the bench at a negedge with rst just released.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic              av;
    logic [REG_AW-1:0] ard;
    logic [XLEN-1:0]   ad;
    logic              lv;
    logic [REG_AW-1:0] lrd;
    logic [XLEN-1:0]   ld;
    logic              ewe;
    logic [REG_AW-1:0] ea;
    logic [XLEN-1:0]   ed;
  } vec_t;

  function automatic vec_t mk(input logic av, input logic [REG_AW-1:0] ard, input logic [XLEN-1:0] ad,
                              input logic lv, input logic [REG_AW-1:0] lrd, input logic [XLEN-1:0] ld,
                              input logic ewe, input logic [REG_AW-1:0] ea, input logic [XLEN-1:0] ed);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad;
    v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.ewe = ewe; v.ea = ea; v.ed = ed;
    return v;
  endfunction

  vec_t vecs[8];

  // ---------------- stream helper ----------------
  logic [REG_AW-1:0] a_rd[4];
  logic [XLEN-1:0]   a_dat[4];
  logic [REG_AW-1:0] l_rd[4];
  logic [XLEN-1:0]   l_dat[4];
  logic [REG_AW-1:0] got_rd[$];
  logic [XLEN-1:0]   got_dat[$];
  logic [REG_AW-1:0] exp_rd[$];
  logic [XLEN-1:0]   exp_dat[$];

  // Producers follow the handshake; every observed write is recorded in order.
  task automatic run_stream(input int na, input int nl, output int alu_stall);
    int ai;
    int li;
    ai = 0;
    li = 0;
    alu_stall = 0;
    got_rd.delete();
    got_dat.delete();
    for (int c = 0; c < 4 * (na + nl) + 4 && got_rd.size() < na + nl; c++) begin
      alu_valid = (ai < na);
      if (ai < na) begin
        alu_rd   = a_rd[ai];
        alu_data = a_dat[ai];
      end
      lsu_valid = (li < nl);
      if (li < nl) begin
        lsu_rd   = l_rd[li];
        lsu_data = l_dat[li];
      end
      #1;
      if (alu_valid && !alu_ready) alu_stall++;
      if (alu_valid && alu_ready) ai++;
      if (lsu_valid && lsu_ready) li++;
      @(negedge clk);
      if (write_enable) begin
        got_rd.push_back(waddr);
        got_dat.push_back(wdata);
        $display("stream write x%0d = %h", waddr, wdata);
      end
    end
    idle_inputs();
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, "_count"}, 64'(got_rd.size()), 64'(exp_rd.size()));
    for (int k = 0; k < got_rd.size() && k < exp_rd.size(); k++) begin
      chk($sformatf("%s_rd%0d", tag, k), 64'(got_rd[k]), 64'(exp_rd[k]));
      chk($sformatf("%s_data%0d", tag, k), got_dat[k], exp_dat[k]);
    end
  endtask

  // ---------------- random-phase model state ----------------
  logic [NREG-1:0]   m_busy;
  logic              m_we;
  logic [REG_AW-1:0] m_waddr;
  logic [XLEN-1:0]   m_wdata;
  int                contests;
  logic              alu_hold;
  logic              lsu_hold;
  logic              e_ar;
  logic              e_lr;
  logic              a_acc;
  logic              l_acc;
  logic [REG_AW-1:0] acc_rd;
  logic [XLEN-1:0]   acc_data;
  int                stall;

  initial begin
    rst = 1'b0;
    idle_inputs();

    // ---- reset holds everything quiet even with traffic offered ----
    alu_valid   = 1'b1;
    alu_rd      = 5'd5;
    alu_data    = 64'h55;
    issue_valid = 1'b1;
    issue_rd    = 5'd5;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_alu_ready", 64'(alu_ready), 64'd0);
      chk("rst_lsu_ready", 64'(lsu_ready), 64'd0);
      chk("rst_we", 64'(write_enable), 64'd0);
      chk("rst_waddr", 64'(waddr), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      $display("reset cycle %0d: alu_ready=%0b we=%0b busy=%h", i, alu_ready, write_enable, busy);
    end

    // ---- table: single-source results back to back, idle and x0 rows ----
    vecs[0] = mk(1'b1, 5'd7,  64'hDEAD_BEEF,          1'b0, 5'd0,  64'h0,  1'b1, 5'd7,  64'hDEAD_BEEF);
    vecs[1] = mk(1'b0, 5'd0,  64'h0,                  1'b0, 5'd0,  64'h0,  1'b0, 5'd0,  64'h0);
    vecs[2] = mk(1'b0, 5'd0,  64'h0,                  1'b1, 5'd3,  64'h11, 1'b1, 5'd3,  64'h11);
    vecs[3] = mk(1'b1, 5'd0,  64'hFF,                 1'b0, 5'd0,  64'h0,  1'b0, 5'd0,  64'h0);
    vecs[4] = mk(1'b0, 5'd0,  64'h0,                  1'b1, 5'd31, '1,     1'b1, 5'd31, '1);
    vecs[5] = mk(1'b1, 5'd1,  64'h1234_5678_9ABC_DEF0, 1'b0, 5'd0, 64'h0,  1'b1, 5'd1,  64'h1234_5678_9ABC_DEF0);
    vecs[6] = mk(1'b0, 5'd0,  64'h0,                  1'b1, 5'd0,  64'hAA, 1'b0, 5'd0,  64'h0);
    vecs[7] = mk(1'b1, 5'd30, 64'h5,                  1'b0, 5'd0,  64'h0,  1'b1, 5'd30, 64'h5);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      alu_valid = vecs[i].av;
      alu_rd    = vecs[i].ard;
      alu_data  = vecs[i].ad;
      lsu_valid = vecs[i].lv;
      lsu_rd    = vecs[i].lrd;
      lsu_data  = vecs[i].ld;
      #1;
      if (vecs[i].av) chk($sformatf("tbl%0d_alu_ready", i), 64'(alu_ready), 64'd1);
      if (vecs[i].lv) chk($sformatf("tbl%0d_lsu_ready", i), 64'(lsu_ready), 64'd1);
      @(negedge clk);
      chk($sformatf("tbl%0d_we", i), 64'(write_enable), 64'(vecs[i].ewe));
      chk($sformatf("tbl%0d_waddr", i), 64'(waddr), 64'(vecs[i].ea));
      chk($sformatf("tbl%0d_wdata", i), wdata, vecs[i].ed);
      $display("vector %0d: we=%0b waddr=%0d wdata=%h", i, write_enable, waddr, wdata);
    end
    idle_inputs();
    @(negedge clk);
    chk("tbl_tail_we", 64'(write_enable), 64'd0);
    chk("tbl_tail_wdata", wdata, 64'd0);

    // ---- two-way contention, one result each ----
    do_reset();
    a_rd[0] = 5'd4; a_dat[0] = 64'h22;
    l_rd[0] = 5'd3; l_dat[0] = 64'h11;
    exp_rd.delete();
    exp_dat.delete();
`ifdef WB_ROUND_ROBIN_EN
    exp_rd.push_back(5'd4); exp_dat.push_back(64'h22);
    exp_rd.push_back(5'd3); exp_dat.push_back(64'h11);
`else
    exp_rd.push_back(5'd3); exp_dat.push_back(64'h11);
    exp_rd.push_back(5'd4); exp_dat.push_back(64'h22);
`endif
    run_stream(1, 1, stall);
    cmp_stream("contend");
`ifdef WB_ROUND_ROBIN_EN
    chk("contend_alu_stall", 64'(stall), 64'd0);
`else
    chk("contend_alu_stall", 64'(stall), 64'd1);
`endif

    // ---- both sources streaming four results ----
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a_rd[i]  = REG_AW'(10 + i);
      a_dat[i] = 64'hA000 + 64'(i);
      l_rd[i]  = REG_AW'(20 + i);
      l_dat[i] = 64'hB000 + 64'(i);
    end
    exp_rd.delete();
    exp_dat.delete();
`ifdef WB_ROUND_ROBIN_EN
    for (int i = 0; i < 4; i++) begin
      exp_rd.push_back(a_rd[i]); exp_dat.push_back(a_dat[i]);
      exp_rd.push_back(l_rd[i]); exp_dat.push_back(l_dat[i]);
    end
`else
    for (int i = 0; i < 4; i++) begin
      exp_rd.push_back(l_rd[i]); exp_dat.push_back(l_dat[i]);
    end
    for (int i = 0; i < 4; i++) begin
      exp_rd.push_back(a_rd[i]); exp_dat.push_back(a_dat[i]);
    end
`endif
    run_stream(4, 4, stall);
    cmp_stream("stream");
`ifdef WB_ROUND_ROBIN_EN
    chk("stream_alu_stall", 64'(stall), 64'd3);
`else
    chk("stream_alu_stall", 64'(stall), 64'd4);
`endif

    // ---- scoreboard: set, set-wins over clear, clear ----
    do_reset();
    chk("sb_initial_b9", 64'(busy[9]), 64'd0);
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    @(negedge clk);
    chk("sb_set_b9", 64'(busy[9]), 64'd1);
    alu_valid = 1'b1;
    alu_rd    = 5'd9;
    alu_data  = 64'h99;
    @(negedge clk);
    chk("sb_setwins_b9", 64'(busy[9]), 64'd1);
    chk("sb_setwins_we", 64'(write_enable), 64'd1);
    issue_valid = 1'b0;
    alu_data    = 64'h98;
    @(negedge clk);
    chk("sb_clear_b9", 64'(busy[9]), 64'd0);
    chk("sb_clear_wdata", wdata, 64'h98);
    $display("scoreboard sequence: busy=%h", busy);
    idle_inputs();

    // ---- x0 result, x0 issue, then reset right after an accept ----
    do_reset();
    alu_valid   = 1'b1;
    alu_rd      = 5'd0;
    alu_data    = 64'hFF;
    issue_valid = 1'b1;
    issue_rd    = 5'd0;
    #1;
    chk("x0_alu_ready", 64'(alu_ready), 64'd1);
    @(negedge clk);
    chk("x0_we", 64'(write_enable), 64'd0);
    chk("x0_waddr", 64'(waddr), 64'd0);
    chk("x0_wdata", wdata, 64'd0);
    chk("x0_busy", 64'(busy), 64'd0);
    alu_valid = 1'b0;
    issue_rd  = 5'd12;
    @(negedge clk);
    chk("x12_issue_b12", 64'(busy[12]), 64'd1);
    alu_valid = 1'b1;
    alu_rd    = 5'd12;
    alu_data  = 64'hC;
    @(negedge clk);
    chk("x12_accept_b12", 64'(busy[12]), 64'd1);
    chk("x12_accept_waddr", 64'(waddr), 64'd12);
    rst = 1'b0;
    idle_inputs();
    #1;
    chk("midrst_we", 64'(write_enable), 64'd0);
    chk("midrst_waddr", 64'(waddr), 64'd0);
    @(negedge clk);
    chk("midrst_b12", 64'(busy[12]), 64'd0);
    chk("midrst_we_after", 64'(write_enable), 64'd0);
    $display("mid-operation reset: we=%0b busy=%h", write_enable, busy);

    // ---- randomized traffic against the behavioural model ----
    do_reset();
    m_busy   = '0;
    m_we     = 1'b0;
    m_waddr  = '0;
    m_wdata  = '0;
    contests = 0;
    alu_hold = 1'b0;
    lsu_hold = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!alu_hold) begin
        alu_valid = ($urandom_range(0, 99) < 60);
        alu_rd    = REG_AW'($urandom_range(0, 7));
        alu_data  = {$urandom, $urandom};
      end
      if (!lsu_hold) begin
        lsu_valid = ($urandom_range(0, 99) < 50);
        lsu_rd    = REG_AW'($urandom_range(0, 7));
        lsu_data  = {$urandom, $urandom};
      end
      issue_valid = ($urandom_range(0, 99) < 50);
      issue_rd    = REG_AW'($urandom_range(0, 7));
      #1;
`ifdef WB_ROUND_ROBIN_EN
      // Contests alternate ALU, LSU, ALU, ... counted from reset.
      e_ar = alu_valid && (!lsu_valid || (contests % 2 == 0));
      e_lr = lsu_valid && (!alu_valid || (contests % 2 == 1));
`else
      e_ar = !lsu_valid;
      e_lr = 1'b1;
`endif
      chk("rnd_alu_ready", 64'(alu_ready), 64'(e_ar));
      chk("rnd_lsu_ready", 64'(lsu_ready), 64'(e_lr));
      chk("rnd_we", 64'(write_enable), 64'(m_we));
      chk("rnd_waddr", 64'(waddr), 64'(m_waddr));
      chk("rnd_wdata", wdata, m_wdata);
      chk("rnd_busy", 64'(busy), 64'(m_busy));
      if (write_enable) $display("random cycle %0d: write x%0d = %h", c, waddr, wdata);

      a_acc = alu_valid && e_ar;
      l_acc = lsu_valid && e_lr;
      if (alu_valid && lsu_valid) contests++;
      acc_rd   = l_acc ? lsu_rd : alu_rd;
      acc_data = l_acc ? lsu_data : alu_data;
      if ((a_acc || l_acc) && acc_rd != 0) begin
        m_we    = 1'b1;
        m_waddr = acc_rd;
        m_wdata = acc_data;
      end else begin
        m_we    = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
      end
      if (a_acc || l_acc) m_busy[acc_rd] = 1'b0;
      if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      alu_hold = alu_valid && !a_acc;
      lsu_hold = lsu_valid && !l_acc;
      @(negedge clk);
    end
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
